// File: rtl/integral_stream_gen.sv
// Streaming integral-image generator: one registered S(x,y) (and optional squared sum) per accepted raster pixel.
// Line buffers hold the previous row's column integrals; a result appears the cycle after its pixel is accepted.
module integral_stream_gen #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 20,
  parameter int IMG_H = 20,
  parameter int SQ_EN = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [31:0]      out_sqsum,
  output logic [8:0]       out_col,
  output logic [8:0]       out_row,
  output logic             out_eol,
  output logic             out_eof,
  output logic             frame_done,
  output logic             frame_abort
);

  localparam int NPIX  = IMG_W * IMG_H;
  localparam int SUM_W = PIX_W + $clog2(NPIX + 1);
  localparam int SQ_W  = 2 * PIX_W + $clog2(NPIX + 1);
  localparam int AW    = $clog2(IMG_W);

  generate
    if (SUM_W > 32) begin : g_sum_w_err
      $error("integral_stream_gen: SUM_W exceeds 32 bits");
    end
    if ((SQ_EN != 0) && (SQ_W > 32)) begin : g_sq_w_err
      $error("integral_stream_gen: SQ_W exceeds 32 bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [8:0]       col_q, col_d;
  logic [8:0]       row_q, row_d;
  logic [SUM_W-1:0] rowacc_q, rowacc_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_sum_q, out_sum_d;
  logic [8:0]       out_col_q, out_col_d;
  logic [8:0]       out_row_q, out_row_d;
  logic             out_eol_q, out_eol_d;
  logic             out_eof_q, out_eof_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_abort_q, frame_abort_d;

  logic             in_fire, out_fire, proc;
  logic [8:0]       cur_col, cur_row;
  logic [AW-1:0]    idx;
  logic             last_col, last_row;
  logic [SUM_W-1:0] lb_rd, row_sum, sum_new;
  logic [SUM_W-1:0] lbuf_q [IMG_W];

  // en_q keeps the input closed for the cycle right after reset.
  always_comb begin
    in_ready = 1'b0;
    if (en_q) begin
      case (state_q)
        ST_IDLE:   in_ready = 1'b1;
        ST_ACTIVE: in_ready = !out_valid_q || out_ready;
        default:   in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    in_fire  = in_valid && in_ready;
    out_fire = out_valid_q && out_ready;
    proc     = in_fire && ((state_q == ST_ACTIVE) || ((state_q == ST_IDLE) && in_sof));
    cur_col  = in_sof ? 9'd0 : col_q;
    cur_row  = in_sof ? 9'd0 : row_q;
    idx      = cur_col[AW-1:0];
    last_col = (cur_col == 9'(IMG_W - 1));
    last_row = (cur_row == 9'(IMG_H - 1));
    lb_rd    = lbuf_q[idx];
    // Row 0 ignores the line buffer, which also masks leftovers of an aborted frame.
    row_sum  = ((cur_col == 9'd0) ? '0 : rowacc_q) + SUM_W'(in_pix);
    sum_new  = ((cur_row == 9'd0) ? '0 : lb_rd) + row_sum;

    en_d          = 1'b1;
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    rowacc_d      = rowacc_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    out_col_d     = out_col_q;
    out_row_d     = out_row_q;
    out_eol_d     = out_eol_q;
    out_eof_d     = out_eof_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;

    if (out_fire) begin
      out_valid_d = 1'b0;
    end

    if (proc) begin
      out_valid_d   = 1'b1;
      rowacc_d      = row_sum;
      out_sum_d     = 32'(sum_new);
      out_col_d     = cur_col;
      out_row_d     = cur_row;
      out_eol_d     = last_col;
      out_eof_d     = last_col && last_row;
      frame_abort_d = (state_q == ST_ACTIVE) && in_sof;
      if (last_col) begin
        col_d = 9'd0;
        row_d = last_row ? 9'd0 : cur_row + 9'd1;
      end else begin
        col_d = cur_col + 9'd1;
        row_d = cur_row;
      end
      state_d = (last_col && last_row) ? ST_DONE : ST_ACTIVE;
    end

    if ((state_q == ST_DONE) && out_fire && out_eof_q) begin
      state_d      = ST_IDLE;
      frame_done_d = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q       <= ST_IDLE;
      en_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      rowacc_q      <= '0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= '0;
      out_col_q     <= '0;
      out_row_q     <= '0;
      out_eol_q     <= 1'b0;
      out_eof_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      en_q          <= en_d;
      col_q         <= col_d;
      row_q         <= row_d;
      rowacc_q      <= rowacc_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      out_col_q     <= out_col_d;
      out_row_q     <= out_row_d;
      out_eol_q     <= out_eol_d;
      out_eof_q     <= out_eof_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (proc) begin
      lbuf_q[idx] <= sum_new;
    end
  end

  generate
    if (SQ_EN != 0) begin : g_sq
      logic [SQ_W-1:0] psq, rowsq_sum, sq_new, lbsq_rd;
      logic [SQ_W-1:0] rowsq_q, rowsq_d;
      logic [31:0]     out_sqsum_q, out_sqsum_d;
      logic [SQ_W-1:0] lbsq_q [IMG_W];

      always_comb begin
        psq         = SQ_W'(in_pix) * SQ_W'(in_pix);
        lbsq_rd     = lbsq_q[idx];
        rowsq_sum   = ((cur_col == 9'd0) ? '0 : rowsq_q) + psq;
        sq_new      = ((cur_row == 9'd0) ? '0 : lbsq_rd) + rowsq_sum;
        rowsq_d     = rowsq_q;
        out_sqsum_d = out_sqsum_q;
        if (proc) begin
          rowsq_d     = rowsq_sum;
          out_sqsum_d = 32'(sq_new);
        end
      end

      always_ff @(posedge Clk) begin
        if (!Reset_n) begin
          rowsq_q     <= '0;
          out_sqsum_q <= '0;
        end else begin
          rowsq_q     <= rowsq_d;
          out_sqsum_q <= out_sqsum_d;
        end
      end

      always_ff @(posedge Clk) begin
        if (proc) begin
          lbsq_q[idx] <= sq_new;
        end
      end

      assign out_sqsum = out_sqsum_q;
    end else begin : g_no_sq
      assign out_sqsum = 32'd0;
    end
  endgenerate

  assign out_valid   = out_valid_q;
  assign out_sum     = out_sum_q;
  assign out_col     = out_col_q;
  assign out_row     = out_row_q;
  assign out_eol     = out_eol_q;
  assign out_eof     = out_eof_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

endmodule
